seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Drives the Basys3 4-digit multiplexed 7-segment display (seg/an/dp) from a 16-bit hex value written by the SoC.
- Sits directly downstream of the soc instance in the board top level, on the core_clk domain with the same rst_n.
- Shows the value as four hex digits. Scans the anodes at a fixed refresh rate, with a blanking gap between digits to suppress ghosting.
- Display updates are tear-free: new values are applied only at frame boundaries.

Parameters:
- CLK_FREQ, 10_000_000: core clock frequency in Hz.
- REFRESH_HZ, 1000: full-frame (4-digit) refresh rate in Hz. DIGIT_CYCLES = CLK_FREQ/(4*REFRESH_HZ), integer division.
- BLANK_CYCLES, 16: cycles at the start of each digit slot with all anodes off.
- Elaboration check: DIGIT_CYCLES >= 2 and 1 <= BLANK_CYCLES < DIGIT_CYCLES, else $fatal.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- value_i  input  16  hex value; digit d = value_i[4d+3:4d]; digit 0 is rightmost (an[0]).
- dp_i  input  4  decimal point enable per digit, active high.
- en_i  input  4  digit enable, active high; a disabled digit keeps its anode off during its slot.
- value_we_i  input  1  write strobe; captures value_i and dp_i into the shadow registers.
- seg_o  output  7  segments, active low; bit0 = a … bit6 = g.
- an_o  output  4  anodes, active low.
- dp_o  output  1  decimal point, active low.
- frame_o  output  1  one-cycle pulse on the cycle the display registers reload (frame boundary).

Behaviour:
- Reset (async assert, sync deassert handled upstream): an_o = 4'hF, seg_o = 7'h7F, dp_o = 1, frame_o = 0. Shadow and display value/dp = 0. slot_cnt = 0, digit_idx = 0.
- Counters:
  - slot_cnt counts 0..DIGIT_CYCLES-1, then wraps to 0 and increments digit_idx (2 bits, wraps 3->0).
  - Frame boundary = slot_cnt wrap while digit_idx == 3.
- Shadow write: on a clk edge with value_we_i = 1, shadow_val <= value_i and shadow_dp <= dp_i. Multiple writes within a frame: last wins.
- Display reload:
  - At the frame boundary, disp_val/disp_dp <= shadow values and frame_o = 1 for exactly that cycle.
  - If value_we_i is high on the boundary cycle, value_i/dp_i bypass the shadow and load directly into the display.
- Outputs are registered, computed from the counter state of the current cycle. Values below are output values in the cycle after the counter holds the given state.
  - slot_cnt < BLANK_CYCLES: an_o = 4'hF, seg_o = 7'h7F, dp_o = 1.
  - slot_cnt >= BLANK_CYCLES and en_i[digit_idx] = 1: an_o = ~(4'b1 << digit_idx); seg_o = hex decode of disp_val nibble; dp_o = ~disp_dp[digit_idx].
  - en_i[digit_idx] = 0: outputs blanked for the whole slot. Slot timing is unchanged.
- Latency and timing:
  - After rst_n deasserts, an_o[0] first goes low BLANK_CYCLES+1 clock edges later and stays low for DIGIT_CYCLES-BLANK_CYCLES cycles.
  - Each digit repeats with period 4*DIGIT_CYCLES.
  - Never more than one anode low at a time.
- Hex decode, active low gfedcba:
  - 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000
  - 8:0000000 9:0010000 A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110
- en_i is sampled live (not shadowed); changes take effect in the next registered output.
- Reset mid-frame: all outputs go to reset values immediately (async). Scan restarts at digit 0, slot 0.

Decomposition:
- Package seg7_pkg:
  - constant localparams for the blank pattern (7'h7F) and anode-off value (4'hF).
  - function hex_to_seg(logic [3:0]) returning logic [6:0] (the table above).
- Natural sub-module: seg7_decoder (combinational nibble -> segment code wrapping hex_to_seg), reusable by other display peripherals.
- Counter/shadow/output logic stays in seg7_scan_driver.

Test Plan (CLK_FREQ=4000, REFRESH_HZ=100 -> DIGIT_CYCLES=10; BLANK_CYCLES=2):
- Reset then write value_i=16'h1234, dp_i=0, en_i=4'hF:
  - an_o[0] low for 8 of every 10 cycles, seg_o=0011001 (4).
  - Then an_o[1]/0110000, an_o[2]/0100100, an_o[3]/1111001.
  - Each digit period is 40 cycles.
- Write 16'hABCD mid-frame (digit 1 active):
  - seg_o unchanged until frame_o pulses.
  - Next frame shows digit0 = 0100001 (d), digit3 = 0001000 (A).
- value_we_i asserted on the frame_o cycle with 16'hFFFF: the next frame shows 0001110 on all digits (bypass); no frame with the stale value.
- en_i=4'b0101, dp_i=4'b0100, value 16'h8888: an_o[1] and an_o[3] never low; dp_o=0 only while an_o[2] is low; seg_o=0000000 when lit.
- Assert rst_n=0 mid-slot of digit 2: an_o=4'hF, seg_o=7'h7F, dp_o=1 in the same cycle (async). After release, scanning resumes at an_o[0] after 3 edges and displays 16'h0000 (1000000).
- Over 1000 cycles with random writes: assertion holds that at most one an_o bit is low, and frame_o pulses exactly every 40 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and hex-to-segment table for 7-segment display peripherals.
//   SEG_BLANK  all segments off (active low)
//   AN_OFF     all anodes off (active low)
//   hex_to_seg nibble -> active-low gfedcba segment code
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational hex nibble to active-low 7-segment code.
//   nibble  in  4  hex digit
//   seg     out 7  segments, active low, bit0 = a .. bit6 = g
import seg7_pkg::*;

module seg7_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 4-digit 7-segment scanner with blanking gaps and tear-free frame reload.
//   clk         in  1   core clock
//   rst_n       in  1   asynchronous active-low reset
//   value_i     in  16  hex value, digit 0 (rightmost) in bits [3:0]
//   dp_i        in  4   decimal point enable per digit, active high
//   en_i        in  4   digit enable, active high, sampled live
//   value_we_i  in  1   write strobe into the shadow registers
//   seg_o       out 7   segments, active low
//   an_o        out 4   anodes, active low
//   dp_o        out 1   decimal point, active low
//   frame_o     out 1   high on the cycle whose closing edge reloads the display registers
import seg7_pkg::*;

module seg7_scan_driver #(
    parameter int CLK_FREQ     = 10_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  en_i,
    input  logic        value_we_i,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam int DIGIT_CYCLES = CLK_FREQ / (4 * REFRESH_HZ);
    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    generate
        if (DIGIT_CYCLES < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_params
            $fatal(1, "seg7_scan_driver: need DIGIT_CYCLES >= 2 and 1 <= BLANK_CYCLES < DIGIT_CYCLES");
        end
    endgenerate

    logic [CW-1:0] slot_cnt;
    logic [1:0]    digit_idx;
    logic [15:0]   shadow_val, disp_val;
    logic [3:0]    shadow_dp, disp_dp;
    logic [6:0]    dec_seg;
    logic          slot_wrap, lit;

    assign slot_wrap = slot_cnt == CW'(DIGIT_CYCLES - 1);
    assign frame_o   = slot_wrap && digit_idx == 2'd3;
    assign lit       = slot_cnt >= CW'(BLANK_CYCLES) && en_i[digit_idx];

    seg7_decoder u_dec (
        .nibble (disp_val[{digit_idx, 2'b00} +: 4]),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                digit_idx <= digit_idx + 1'b1;
        end
    end

    // A write landing on the boundary cycle goes straight to the display so no frame shows the stale value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
        end else begin
            if (value_we_i) begin
                shadow_val <= value_i;
                shadow_dp  <= dp_i;
            end
            if (frame_o) begin
                disp_val <= value_we_i ? value_i : shadow_val;
                disp_dp  <= value_we_i ? dp_i : shadow_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_o  <= AN_OFF;
            seg_o <= SEG_BLANK;
            dp_o  <= 1'b1;
        end else begin
            an_o  <= lit ? ~(4'b1 << digit_idx) : AN_OFF;
            seg_o <= lit ? dec_seg : SEG_BLANK;
            dp_o  <= lit ? ~disp_dp[digit_idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for seg7_scan_driver (DIGIT_CYCLES=10, BLANK_CYCLES=2).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  en = 4'hF;
    logic        we = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dpo;
    logic        frame;

    int checks = 0;
    int errors = 0;
    int cyc;

    seg7_scan_driver #(
        .CLK_FREQ     (4000),
        .REFRESH_HZ   (100),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_i    (value),
        .dp_i       (dp),
        .en_i       (en),
        .value_we_i (we),
        .seg_o      (seg),
        .an_o       (an),
        .dp_o       (dpo),
        .frame_o    (frame)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    // Advance to the falling edge where cyc == n (bounded).
    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cyc !== n) begin
            errors++;
            $display("FAIL wait_cyc: reached cyc %0d, required %0d", cyc, n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (an !== 4'hF)     begin errors++; $display("FAIL reset_an: got %h, expected f", an); end
        if (seg !== 7'h7F)   begin errors++; $display("FAIL reset_seg: got %b, expected 1111111", seg); end
        if (dpo !== 1'b1)    begin errors++; $display("FAIL reset_dp: got %b, expected 1", dpo); end
        if (frame !== 1'b0)  begin errors++; $display("FAIL reset_frame: got %b, expected 0", frame); end
        rst_n = 1'b1;
        value = 16'h1234;
        dp    = 4'h0;
        en    = 4'hF;
        we    = 1'b1;
        wait_cyc(1);
        we = 1'b0;
    endtask

    task automatic test_latency;
        wait_cyc(2);
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL lat_blank: got %h, expected f", an); end
        wait_cyc(3);
        checks += 2;
        if (an !== 4'hE)         begin errors++; $display("FAIL lat_an0: got %h, expected e", an); end
        if (seg !== 7'b1000000)  begin errors++; $display("FAIL lat_seg0: got %b, expected 1000000", seg); end
        wait_cyc(10);
        checks++;
        if (an !== 4'hE) begin errors++; $display("FAIL lat_an0_end: got %h, expected e", an); end
        wait_cyc(11);
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL lat_gap1: got %h, expected f", an); end
        wait_cyc(13);
        checks++;
        if (an !== 4'hD) begin errors++; $display("FAIL lat_an1: got %h, expected d", an); end
        wait_cyc(38);
        checks++;
        if (frame !== 1'b0) begin errors++; $display("FAIL frame_pre: got %b, expected 0", frame); end
        wait_cyc(39);
        checks++;
        if (frame !== 1'b1) begin errors++; $display("FAIL frame_at: got %b, expected 1", frame); end
        wait_cyc(40);
        checks++;
        if (frame !== 1'b0) begin errors++; $display("FAIL frame_post: got %b, expected 0", frame); end
    endtask

    task automatic test_scan;
        logic [3:0] an_exp [4];
        logic [6:0] seg_exp [4];
        an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        for (int d = 0; d < 5; d++) begin
            wait_cyc(43 + 10 * d);
            checks += 2;
            if (an !== an_exp[d % 4])
                begin errors++; $display("FAIL scan_an d%0d: got %h, expected %h", d, an, an_exp[d % 4]); end
            if (seg !== seg_exp[d % 4])
                begin errors++; $display("FAIL scan_seg d%0d: got %b, expected %b", d, seg, seg_exp[d % 4]); end
        end
    endtask

    task automatic test_midframe_write;
        wait_cyc(93);
        value = 16'hABCD;
        we    = 1'b1;
        wait_cyc(94);
        we = 1'b0;
        wait_cyc(95);
        checks++;
        if (seg !== 7'b0110000) begin errors++; $display("FAIL mid_hold1: got %b, expected 0110000", seg); end
        wait_cyc(103);
        checks++;
        if (seg !== 7'b0100100) begin errors++; $display("FAIL mid_hold2: got %b, expected 0100100", seg); end
        wait_cyc(113);
        checks++;
        if (seg !== 7'b1111001) begin errors++; $display("FAIL mid_hold3: got %b, expected 1111001", seg); end
        wait_cyc(123);
        checks += 2;
        if (an !== 4'hE)        begin errors++; $display("FAIL mid_new_an0: got %h, expected e", an); end
        if (seg !== 7'b0100001) begin errors++; $display("FAIL mid_new_d0: got %b, expected 0100001", seg); end
        wait_cyc(153);
        checks += 2;
        if (an !== 4'h7)        begin errors++; $display("FAIL mid_new_an3: got %h, expected 7", an); end
        if (seg !== 7'b0001000) begin errors++; $display("FAIL mid_new_d3: got %b, expected 0001000", seg); end
    endtask

    task automatic test_bypass;
        wait_cyc(159);
        checks++;
        if (frame !== 1'b1) begin errors++; $display("FAIL byp_frame: got %b, expected 1", frame); end
        value = 16'hFFFF;
        we    = 1'b1;
        wait_cyc(160);
        we = 1'b0;
        for (int d = 0; d < 4; d++) begin
            wait_cyc(163 + 10 * d);
            checks++;
            if (seg !== 7'b0001110)
                begin errors++; $display("FAIL byp_seg d%0d: got %b, expected 0001110", d, seg); end
        end
    endtask

    task automatic test_enable;
        wait_cyc(195);
        value = 16'h8888;
        dp    = 4'b0100;
        en    = 4'b0101;
        we    = 1'b1;
        wait_cyc(196);
        we = 1'b0;
        for (int c = 201; c <= 240; c++) begin
            wait_cyc(c);
            checks++;
            if (an[1] !== 1'b1 || an[3] !== 1'b1 || dpo !== (an !== 4'b1011) ||
                (an !== 4'hF && seg !== 7'b0000000) || (an === 4'hF && seg !== 7'h7F))
                begin errors++; $display("FAIL enable cyc %0d: got an=%b dp=%b seg=%b", c, an, dpo, seg); end
        end
        wait_cyc(243);
        checks += 2;
        if (an !== 4'hE)   begin errors++; $display("FAIL en_an0: got %h, expected e", an); end
        if (dpo !== 1'b1)  begin errors++; $display("FAIL en_dp0: got %b, expected 1", dpo); end
        wait_cyc(263);
        checks += 2;
        if (an !== 4'hB)   begin errors++; $display("FAIL en_an2: got %h, expected b", an); end
        if (dpo !== 1'b0)  begin errors++; $display("FAIL en_dp2: got %b, expected 0", dpo); end
    endtask

    task automatic test_async_reset;
        wait_cyc(265);
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (an !== 4'hF)   begin errors++; $display("FAIL arst_an: got %h, expected f", an); end
        if (seg !== 7'h7F) begin errors++; $display("FAIL arst_seg: got %b, expected 1111111", seg); end
        if (dpo !== 1'b1)  begin errors++; $display("FAIL arst_dp: got %b, expected 1", dpo); end
        repeat (2) @(negedge clk);
        en    = 4'hF;
        rst_n = 1'b1;
        wait_cyc(2);
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL arst_gap: got %h, expected f", an); end
        wait_cyc(3);
        checks += 2;
        if (an !== 4'hE)        begin errors++; $display("FAIL arst_an0: got %h, expected e", an); end
        if (seg !== 7'b1000000) begin errors++; $display("FAIL arst_seg0: got %b, expected 1000000", seg); end
        wait_cyc(13);
        checks += 2;
        if (an !== 4'hD)        begin errors++; $display("FAIL arst_an1: got %h, expected d", an); end
        if (seg !== 7'b1000000) begin errors++; $display("FAIL arst_seg1: got %b, expected 1000000", seg); end
    endtask

    task automatic test_random;
        for (int c = 14; c <= 1013; c++) begin
            wait_cyc(c);
            checks += 2;
            if ($countones(~an) > 1)
                begin errors++; $display("FAIL rnd_onehot cyc %0d: got an=%b, expected at most one low", c, an); end
            if (frame !== (c % 40 == 39))
                begin errors++; $display("FAIL rnd_frame cyc %0d: got %b, expected %b", c, frame, c % 40 == 39); end
            we    = ($urandom_range(0, 3) == 0);
            value = 16'($urandom);
            dp    = 4'($urandom);
        end
        we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_scan();
        test_midframe_write();
        test_bypass();
        test_enable();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
